// File: rtl/bp_me_bedrock_register_arb.sv
// -----------------------------------------------------------------------------
// bp_me_bedrock_register_arb
//
// Shares one BedRock-stream register endpoint (CSR/config block) between
// num_req_p command sources. Single-beat commands are arbitrated onto one
// downstream stream. One transaction is outstanding at a time, and its response
// is routed back to the source that was granted.
//
// Each transaction moves through three states:
//   e_idle : arbitration cycle. The grant is registered and nothing is forwarded.
//   e_send : the owner's cmd header/data pass straight through to downstream.
//   e_wait : the downstream response passes straight through to the owner.
// With zero-stall partners a transaction therefore occupies at least 3 cycles.
//
// Parameters
//   num_req_p          number of upstream requesters (>= 1)
//   mem_header_width_p BedRock mem header width (from the processor config)
//   dword_width_p      data beat width (64)
//
// Ports
//   clk_i, reset_i                  clock, synchronous active-high reset
//   mem_cmd_*_i / mem_cmd_*_o       per-requester upstream command streams
//   mem_resp_*_o / mem_resp_*_i     per-requester upstream response streams
//                                   (header/data broadcast; valid to owner only)
//   mem_cmd_*_o (single)            downstream command stream
//   mem_resp_*_i (single)           downstream response stream
//   grant_id_o                      current or last owner index (debug)
//
// Configuration macro
//   BP_ME_REG_ARB_FIXED_PRIO_EN : when defined, fixed priority (lowest index wins)
//                                 with no round-robin pointer. When undefined,
//                                 round-robin starting at rr_ptr.
// -----------------------------------------------------------------------------
module bp_me_bedrock_register_arb
  #(parameter int num_req_p          = 2
   ,parameter int mem_header_width_p = 64
   ,parameter int dword_width_p      = 64
   ,localparam int grant_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
   )
   (input  logic                                           clk_i
   ,input  logic                                           reset_i

   // Upstream command streams
   ,input  logic [num_req_p-1:0][mem_header_width_p-1:0]   mem_cmd_header_i
   ,input  logic [num_req_p-1:0]                           mem_cmd_header_v_i
   ,output logic [num_req_p-1:0]                           mem_cmd_header_ready_and_o
   ,input  logic [num_req_p-1:0]                           mem_cmd_has_data_i
   ,input  logic [num_req_p-1:0][dword_width_p-1:0]        mem_cmd_data_i
   ,input  logic [num_req_p-1:0]                           mem_cmd_data_v_i
   ,output logic [num_req_p-1:0]                           mem_cmd_data_ready_and_o
   ,input  logic [num_req_p-1:0]                           mem_cmd_last_i

   // Upstream response streams
   ,output logic [num_req_p-1:0][mem_header_width_p-1:0]   mem_resp_header_o
   ,output logic [num_req_p-1:0]                           mem_resp_header_v_o
   ,input  logic [num_req_p-1:0]                           mem_resp_header_ready_and_i
   ,output logic [num_req_p-1:0]                           mem_resp_has_data_o
   ,output logic [num_req_p-1:0][dword_width_p-1:0]        mem_resp_data_o
   ,output logic [num_req_p-1:0]                           mem_resp_data_v_o
   ,input  logic [num_req_p-1:0]                           mem_resp_data_ready_and_i
   ,output logic [num_req_p-1:0]                           mem_resp_last_o

   // Downstream command stream
   ,output logic [mem_header_width_p-1:0]                  mem_cmd_header_o
   ,output logic                                           mem_cmd_header_v_o
   ,input  logic                                           mem_cmd_header_ready_and_i
   ,output logic                                           mem_cmd_has_data_o
   ,output logic [dword_width_p-1:0]                       mem_cmd_data_o
   ,output logic                                           mem_cmd_data_v_o
   ,input  logic                                           mem_cmd_data_ready_and_i
   ,output logic                                           mem_cmd_last_o

   // Downstream response stream
   ,input  logic [mem_header_width_p-1:0]                  mem_resp_header_i
   ,input  logic                                           mem_resp_header_v_i
   ,output logic                                           mem_resp_header_ready_and_o
   ,input  logic                                           mem_resp_has_data_i
   ,input  logic [dword_width_p-1:0]                       mem_resp_data_i
   ,input  logic                                           mem_resp_data_v_i
   ,output logic                                           mem_resp_data_ready_and_o
   ,input  logic                                           mem_resp_last_i

   ,output logic [grant_width_lp-1:0]                      grant_id_o
   );

    typedef enum logic [1:0] {e_idle, e_send, e_wait} state_e;

    state_e                    state_reg;
    logic [grant_width_lp-1:0] grant_reg;
    logic                      cmd_has_data_reg;
    logic                      cmd_hdr_done_reg, cmd_data_done_reg;
    logic                      resp_hdr_done_reg, resp_data_done_reg, resp_has_data_reg;
`ifndef BP_ME_REG_ARB_FIXED_PRIO_EN
    logic [grant_width_lp-1:0] rr_ptr_reg;
`endif

    // Arbitration: scan from the highest offset down so the lowest offset wins.
    logic [grant_width_lp-1:0] pick, cand;
    logic                      pick_v;
    always_comb begin
        pick   = '0;
        cand   = '0;
        pick_v = 1'b0;
        for (int i = num_req_p-1; i >= 0; i--) begin
`ifdef BP_ME_REG_ARB_FIXED_PRIO_EN
            cand = grant_width_lp'(i);
`else
            cand = grant_width_lp'((int'(rr_ptr_reg) + i) % num_req_p);
`endif
            if (mem_cmd_header_v_i[cand]) begin
                pick   = cand;
                pick_v = 1'b1;
            end
        end
    end

    // Gating with ~reset_i keeps a transfer from completing in the reset cycle itself.
    logic in_send, in_wait;
    assign in_send = (state_reg == e_send) & ~reset_i;
    assign in_wait = (state_reg == e_wait) & ~reset_i;

    // Downstream command: the owner's stream passes through and a finished channel drops valid.
    assign mem_cmd_header_o   = mem_cmd_header_i[grant_reg];
    assign mem_cmd_data_o     = mem_cmd_data_i[grant_reg];
    assign mem_cmd_last_o     = mem_cmd_last_i[grant_reg];
    assign mem_cmd_has_data_o = cmd_has_data_reg;
    assign mem_cmd_header_v_o = in_send & ~cmd_hdr_done_reg & mem_cmd_header_v_i[grant_reg];
    assign mem_cmd_data_v_o   = in_send & cmd_has_data_reg & ~cmd_data_done_reg
                              & mem_cmd_data_v_i[grant_reg];

    logic cmd_hdr_fire, cmd_data_fire, cmd_done;
    assign cmd_hdr_fire  = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
    assign cmd_data_fire = mem_cmd_data_v_o & mem_cmd_data_ready_and_i;
    assign cmd_done      = (cmd_hdr_done_reg | cmd_hdr_fire)
                         & (~cmd_has_data_reg | cmd_data_done_reg | cmd_data_fire);

    // Downstream response: the owner's readies pass back down.
    logic resp_hdr_v, resp_data_v, resp_hdr_fire, resp_data_fire;
    logic resp_need_data, resp_done;
    assign resp_hdr_v  = in_wait & ~resp_hdr_done_reg & mem_resp_header_v_i;
    assign resp_data_v = in_wait & ~resp_data_done_reg & mem_resp_data_v_i;
    assign mem_resp_header_ready_and_o = in_wait & ~resp_hdr_done_reg
                                       & mem_resp_header_ready_and_i[grant_reg];
    assign mem_resp_data_ready_and_o   = in_wait & ~resp_data_done_reg
                                       & mem_resp_data_ready_and_i[grant_reg];
    assign resp_hdr_fire  = resp_hdr_v & mem_resp_header_ready_and_o;
    assign resp_data_fire = resp_data_v & mem_resp_data_ready_and_o;

    // has_data is taken from the header while it is live and from the latched copy after it is accepted.
    assign resp_need_data = resp_hdr_done_reg ? resp_has_data_reg : mem_resp_has_data_i;
    assign resp_done      = (resp_hdr_done_reg | resp_hdr_fire)
                          & (~resp_need_data | resp_data_done_reg
                             | (resp_data_fire & mem_resp_last_i));

    // Per-requester fan-out: payload is broadcast, and handshakes are gated to the owner.
    logic [num_req_p-1:0] owner_sel;
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
        assign owner_sel[gi] = (grant_reg == grant_width_lp'(gi));

        assign mem_cmd_header_ready_and_o[gi] = in_send & owner_sel[gi] & ~cmd_hdr_done_reg
                                              & mem_cmd_header_ready_and_i;
        assign mem_cmd_data_ready_and_o[gi]   = in_send & owner_sel[gi] & cmd_has_data_reg
                                              & ~cmd_data_done_reg & mem_cmd_data_ready_and_i;

        assign mem_resp_header_o[gi]   = mem_resp_header_i;
        assign mem_resp_data_o[gi]     = mem_resp_data_i;
        assign mem_resp_has_data_o[gi] = mem_resp_has_data_i;
        assign mem_resp_header_v_o[gi] = owner_sel[gi] & resp_hdr_v;
        assign mem_resp_data_v_o[gi]   = owner_sel[gi] & resp_data_v;
        assign mem_resp_last_o[gi]     = owner_sel[gi] & resp_data_v;
    end

    assign grant_id_o = grant_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg          <= e_idle;
            grant_reg          <= '0;
            cmd_has_data_reg   <= 1'b0;
            cmd_hdr_done_reg   <= 1'b0;
            cmd_data_done_reg  <= 1'b0;
            resp_hdr_done_reg  <= 1'b0;
            resp_data_done_reg <= 1'b0;
            resp_has_data_reg  <= 1'b0;
`ifndef BP_ME_REG_ARB_FIXED_PRIO_EN
            rr_ptr_reg         <= '0;
`endif
        end else begin
            case (state_reg)
                e_idle: begin
                    if (pick_v) begin
                        grant_reg         <= pick;
                        cmd_has_data_reg  <= mem_cmd_has_data_i[pick];
                        cmd_hdr_done_reg  <= 1'b0;
                        cmd_data_done_reg <= 1'b0;
                        state_reg         <= e_send;
                    end
                end
                e_send: begin
                    if (cmd_hdr_fire)  cmd_hdr_done_reg  <= 1'b1;
                    if (cmd_data_fire) cmd_data_done_reg <= 1'b1;
                    if (cmd_done) begin
                        cmd_hdr_done_reg   <= 1'b0;
                        cmd_data_done_reg  <= 1'b0;
                        resp_hdr_done_reg  <= 1'b0;
                        resp_data_done_reg <= 1'b0;
                        state_reg          <= e_wait;
                    end
                end
                e_wait: begin
                    if (resp_hdr_fire) begin
                        resp_hdr_done_reg <= 1'b1;
                        resp_has_data_reg <= mem_resp_has_data_i;
                    end
                    if (resp_data_fire & mem_resp_last_i) resp_data_done_reg <= 1'b1;
                    if (resp_done) begin
                        resp_hdr_done_reg  <= 1'b0;
                        resp_data_done_reg <= 1'b0;
                        state_reg          <= e_idle;
`ifndef BP_ME_REG_ARB_FIXED_PRIO_EN
                        rr_ptr_reg <= (grant_reg == grant_width_lp'(num_req_p-1))
                                    ? '0 : grant_reg + 1'b1;
`endif
                    end
                end
                default: state_reg <= e_idle;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Only single-beat commands are supported, so every accepted data beat must carry last.
    cmd_last_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                 cmd_data_fire |-> mem_cmd_last_o);
`endif

endmodule

// File: tb/tb_bp_me_bedrock_register_arb.sv
// -----------------------------------------------------------------------------
// tb_bp_me_bedrock_register_arb
//
// Directed bench for bp_me_bedrock_register_arb with num_req_p = 2. The bench
// models the upstream requesters and a downstream register endpoint, steps
// one cycle at a time, and records handshakes so that scenario tasks can
// compare them against hand-computed values.
// -----------------------------------------------------------------------------
module tb_bp_me_bedrock_register_arb;
    localparam int N  = 2;
    localparam int HW = 64;
    localparam int DW = 64;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic reset_i;

    logic [N-1:0][HW-1:0] mem_cmd_header_i;
    logic [N-1:0]         mem_cmd_header_v_i, mem_cmd_header_ready_and_o, mem_cmd_has_data_i;
    logic [N-1:0][DW-1:0] mem_cmd_data_i;
    logic [N-1:0]         mem_cmd_data_v_i, mem_cmd_data_ready_and_o, mem_cmd_last_i;
    logic [N-1:0][HW-1:0] mem_resp_header_o;
    logic [N-1:0]         mem_resp_header_v_o, mem_resp_header_ready_and_i, mem_resp_has_data_o;
    logic [N-1:0][DW-1:0] mem_resp_data_o;
    logic [N-1:0]         mem_resp_data_v_o, mem_resp_data_ready_and_i, mem_resp_last_o;
    logic [HW-1:0]        mem_cmd_header_o, mem_resp_header_i;
    logic [DW-1:0]        mem_cmd_data_o, mem_resp_data_i;
    logic mem_cmd_header_v_o, mem_cmd_header_ready_and_i, mem_cmd_has_data_o;
    logic mem_cmd_data_v_o, mem_cmd_data_ready_and_i, mem_cmd_last_o;
    logic mem_resp_header_v_i, mem_resp_header_ready_and_o, mem_resp_has_data_i;
    logic mem_resp_data_v_i, mem_resp_data_ready_and_o, mem_resp_last_i;
    logic [0:0] grant_id_o;

    bp_me_bedrock_register_arb #(.num_req_p(N), .mem_header_width_p(HW), .dword_width_p(DW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .mem_cmd_header_i(mem_cmd_header_i), .mem_cmd_header_v_i(mem_cmd_header_v_i),
        .mem_cmd_header_ready_and_o(mem_cmd_header_ready_and_o), .mem_cmd_has_data_i(mem_cmd_has_data_i),
        .mem_cmd_data_i(mem_cmd_data_i), .mem_cmd_data_v_i(mem_cmd_data_v_i),
        .mem_cmd_data_ready_and_o(mem_cmd_data_ready_and_o), .mem_cmd_last_i(mem_cmd_last_i),
        .mem_resp_header_o(mem_resp_header_o), .mem_resp_header_v_o(mem_resp_header_v_o),
        .mem_resp_header_ready_and_i(mem_resp_header_ready_and_i), .mem_resp_has_data_o(mem_resp_has_data_o),
        .mem_resp_data_o(mem_resp_data_o), .mem_resp_data_v_o(mem_resp_data_v_o),
        .mem_resp_data_ready_and_i(mem_resp_data_ready_and_i), .mem_resp_last_o(mem_resp_last_o),
        .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o),
        .mem_cmd_header_ready_and_i(mem_cmd_header_ready_and_i), .mem_cmd_has_data_o(mem_cmd_has_data_o),
        .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
        .mem_cmd_data_ready_and_i(mem_cmd_data_ready_and_i), .mem_cmd_last_o(mem_cmd_last_o),
        .mem_resp_header_i(mem_resp_header_i), .mem_resp_header_v_i(mem_resp_header_v_i),
        .mem_resp_header_ready_and_o(mem_resp_header_ready_and_o), .mem_resp_has_data_i(mem_resp_has_data_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
        .mem_resp_data_ready_and_o(mem_resp_data_ready_and_o), .mem_resp_last_i(mem_resp_last_i),
        .grant_id_o(grant_id_o));

    // Requester and endpoint model state
    logic [N-1:0]         req_hdr_pend, req_data_pend, req_has;
    logic [N-1:0][HW-1:0] req_hdr;
    logic [N-1:0][DW-1:0] req_data;
    bit                   auto_mode;
    bit  ds_got_hdr, ds_got_data, ds_cmd_has, ds_resp_active, ds_resp_hdr_pend, ds_resp_data_pend;
    int  ds_since_hdr, cmd_data_delay, resp_data_delay, up_wait_cnt;
    logic [HW-1:0] ds_hdr_val, dn_resp_hdr;
    logic [DW-1:0] ds_data_val, dn_resp_data;
    logic          dn_resp_has;
    int  ds_hdr_cnt, ds_data_cnt, txn_done, cyc;
    int  up_hdr_cnt[N], up_data_cnt[N], resp_v_seen[N], data_rdy_seen[N];
    logic [HW-1:0] up_hdr_val[N];
    logic [DW-1:0] up_data_val[N];
    int  grant_log[$];
    int  checks = 0;
    int  errors = 0;

    task automatic clear_tb();
        req_hdr_pend = '0; req_data_pend = '0; req_has = '0; req_hdr = '0; req_data = '0;
        auto_mode = 0;
        ds_got_hdr = 0; ds_got_data = 0; ds_cmd_has = 0; ds_resp_active = 0;
        ds_resp_hdr_pend = 0; ds_resp_data_pend = 0;
        ds_since_hdr = 0; cmd_data_delay = 0; resp_data_delay = 0; up_wait_cnt = 0;
        ds_hdr_val = '0; ds_data_val = '0; dn_resp_hdr = '0; dn_resp_data = '0; dn_resp_has = 0;
        ds_hdr_cnt = 0; ds_data_cnt = 0; txn_done = 0; cyc = 0;
        for (int i = 0; i < N; i++) begin
            up_hdr_cnt[i] = 0; up_data_cnt[i] = 0; resp_v_seen[i] = 0; data_rdy_seen[i] = 0;
            up_hdr_val[i] = '0; up_data_val[i] = '0;
        end
        grant_log.delete();
    endtask

    // Drive all DUT inputs from the model state, then let combinational paths settle.
    task automatic apply();
        for (int i = 0; i < N; i++) begin
            mem_cmd_header_v_i[i] = req_hdr_pend[i];
            mem_cmd_header_i[i]   = req_hdr[i];
            mem_cmd_has_data_i[i] = req_has[i];
            mem_cmd_data_v_i[i]   = req_data_pend[i];
            mem_cmd_data_i[i]     = req_data[i];
            mem_cmd_last_i[i]     = 1'b1;
        end
        mem_cmd_header_ready_and_i = !ds_got_hdr;
        mem_cmd_data_ready_and_i   = !ds_got_data &&
            (ds_got_hdr ? (ds_since_hdr >= cmd_data_delay) : (cmd_data_delay == 0));
        mem_resp_header_v_i   = ds_resp_hdr_pend;
        mem_resp_header_i     = dn_resp_hdr;
        mem_resp_has_data_i   = dn_resp_has;
        mem_resp_data_v_i     = ds_resp_data_pend;
        mem_resp_data_i       = dn_resp_data;
        mem_resp_last_i       = ds_resp_data_pend;
        mem_resp_header_ready_and_i = '1;
        mem_resp_data_ready_and_i   = (up_wait_cnt >= resp_data_delay) ? '1 : '0;
        #1;
    endtask

    // One clock: sample handshakes before the edge, update the model after it.
    task automatic step();
        logic [N-1:0] uh, ud;
        logic dh, dd, drh, drd, any_rdv, dh_has;
        logic [HW-1:0] dh_val;
        logic [DW-1:0] dd_val;
        int gid;
        uh  = mem_cmd_header_v_i & mem_cmd_header_ready_and_o;
        ud  = mem_cmd_data_v_i & mem_cmd_data_ready_and_o;
        dh  = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
        dd  = mem_cmd_data_v_o & mem_cmd_data_ready_and_i;
        drh = mem_resp_header_v_i & mem_resp_header_ready_and_o;
        drd = mem_resp_data_v_i & mem_resp_data_ready_and_o;
        dh_val = mem_cmd_header_o; dd_val = mem_cmd_data_o; dh_has = mem_cmd_has_data_o;
        gid = int'(grant_id_o);
        any_rdv = |mem_resp_data_v_o;
        for (int i = 0; i < N; i++) begin
            if (mem_resp_header_v_o[i] | mem_resp_data_v_o[i]) resp_v_seen[i]++;
            if (mem_cmd_data_ready_and_o[i]) data_rdy_seen[i]++;
            if (mem_resp_header_v_o[i] & mem_resp_header_ready_and_i[i]) begin
                up_hdr_cnt[i]++; up_hdr_val[i] = mem_resp_header_o[i];
            end
            if (mem_resp_data_v_o[i] & mem_resp_data_ready_and_i[i]) begin
                up_data_cnt[i]++; up_data_val[i] = mem_resp_data_o[i];
            end
        end
        @(posedge clk_i); #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (uh[i] && !auto_mode) req_hdr_pend[i] = 1'b0;
            if (ud[i] && !auto_mode) req_data_pend[i] = 1'b0;
        end
        if (ds_got_hdr) ds_since_hdr++;
        if (dh) begin
            ds_got_hdr = 1; ds_hdr_val = dh_val; ds_cmd_has = dh_has; ds_since_hdr = 0;
            ds_hdr_cnt++; grant_log.push_back(gid);
        end
        if (dd) begin ds_got_data = 1; ds_data_val = dd_val; ds_data_cnt++; end
        if (any_rdv) up_wait_cnt++;
        if (drh) ds_resp_hdr_pend = 0;
        if (drd) ds_resp_data_pend = 0;
        if (ds_resp_active && !ds_resp_hdr_pend && !ds_resp_data_pend) begin
            ds_resp_active = 0; ds_got_hdr = 0; ds_got_data = 0; txn_done++;
            $display("txn %0d: cycle %0d owner %0d cmd_hdr %0h", txn_done, cyc, gid, ds_hdr_val);
        end else if (!ds_resp_active && ds_got_hdr && (ds_got_data || !ds_cmd_has)) begin
            ds_resp_active = 1; ds_resp_hdr_pend = 1; ds_resp_data_pend = dn_resp_has; up_wait_cnt = 0;
        end
        apply();
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (txn_done < target && n < budget) begin step(); n++; end
        ok = (txn_done >= target);
    endtask

    function automatic int glog(input int idx);
        return (grant_log.size() > idx) ? grant_log[idx] : -1;
    endfunction

    task automatic test_reset();
        bit fail_any;
        clear_tb();
        reset_i = 1'b1;
        req_hdr_pend[0] = 1'b1; req_data_pend[1] = 1'b1; req_has[1] = 1'b1;
        ds_resp_hdr_pend = 1; ds_resp_data_pend = 1;
        apply();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        fail_any = mem_cmd_header_v_o | mem_cmd_data_v_o | (|mem_cmd_header_ready_and_o)
                 | (|mem_cmd_data_ready_and_o) | (|mem_resp_header_v_o) | (|mem_resp_data_v_o);
        if (fail_any !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got %0b expected 0", fail_any);
        end
        checks++;
        if ({mem_resp_header_ready_and_o, mem_resp_data_ready_and_o} !== 2'b00) begin
            errors++; $display("FAIL reset_resp_ready: got %0b expected 00",
                               {mem_resp_header_ready_and_o, mem_resp_data_ready_and_o});
        end
        checks++;
        if (grant_id_o !== 1'b0) begin
            errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id_o);
        end
        reset_i = 1'b0;
        clear_tb();
        apply();
    endtask

    task automatic test_single_read();
        bit ok;
        clear_tb();
        req_hdr_pend[0] = 1'b1; req_hdr[0] = 64'h0000_0000_0200_0000;
        dn_resp_hdr = 64'h8000_0000_0200_0000; dn_resp_has = 1'b1; dn_resp_data = 64'hdead_beef;
        apply();
        wait_done(1, 50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_done: got %0b expected 1", ok); end
        checks++; if (ds_hdr_val !== 64'h0200_0000) begin
            errors++; $display("FAIL rd_ds_hdr: got %0h expected 2000000", ds_hdr_val); end
        checks++; if (ds_data_cnt !== 0) begin
            errors++; $display("FAIL rd_ds_data_cnt: got %0d expected 0", ds_data_cnt); end
        checks++; if (up_hdr_val[0] !== 64'h8000_0000_0200_0000) begin
            errors++; $display("FAIL rd_resp_hdr: got %0h expected 8000000002000000", up_hdr_val[0]); end
        checks++; if (up_data_val[0] !== 64'hdead_beef || up_data_cnt[0] !== 1) begin
            errors++; $display("FAIL rd_resp_data: got %0h x%0d expected deadbeef x1",
                               up_data_val[0], up_data_cnt[0]); end
        checks++; if (resp_v_seen[1] !== 0) begin
            errors++; $display("FAIL rd_req1_valid: got %0d cycles expected 0", resp_v_seen[1]); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int n;
        clear_tb();
        req_hdr_pend[1] = 1'b1; req_hdr[1] = 64'h300;
        dn_resp_hdr = 64'h1300; dn_resp_has = 1'b1; dn_resp_data = 64'h99; resp_data_delay = 100;
        apply();
        seen = 0; n = 0;
        while (!seen && n < 20) begin step(); n++; seen = mem_resp_data_v_o[1]; end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_reach_wait: got %0b expected 1", seen); end
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({mem_resp_header_v_o, mem_resp_data_v_o, mem_cmd_header_v_o} !== 5'b0) begin
            errors++; $display("FAIL rm_valids: got %0b expected 0",
                               {mem_resp_header_v_o, mem_resp_data_v_o, mem_cmd_header_v_o}); end
        checks++;
        if ({mem_resp_header_ready_and_o, mem_resp_data_ready_and_o} !== 2'b00) begin
            errors++; $display("FAIL rm_resp_ready: got %0b expected 00",
                               {mem_resp_header_ready_and_o, mem_resp_data_ready_and_o}); end
        checks++; if (grant_id_o !== 1'b0) begin
            errors++; $display("FAIL rm_grant: got %0d expected 0", grant_id_o); end
        clear_tb();
        req_hdr_pend = 2'b11; req_hdr[0] = 64'h10; req_hdr[1] = 64'h18;
        apply();
        wait_done(2, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_new_txn: got %0b expected 1", ok); end
        checks++; if (glog(0) !== 0 || glog(1) !== 1) begin
            errors++; $display("FAIL rm_order: got %0d,%0d expected 0,1", glog(0), glog(1)); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_g[4];
`ifdef BP_ME_REG_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        clear_tb();
        auto_mode = 1; req_hdr_pend = 2'b11; req_hdr[0] = 64'h40; req_hdr[1] = 64'h48;
        apply();
        wait_done(4, 100, ok);
        req_hdr_pend = 2'b00; auto_mode = 0;
        apply();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_done: got %0b expected 1", ok); end
        checks++; if (cyc !== 12) begin
            errors++; $display("FAIL rr_occupancy: got %0d cycles expected 12", cyc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (glog(k) !== exp_g[k]) begin
                errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, glog(k), exp_g[k]); end
        end
    endtask

    task automatic test_single_write();
        bit ok;
        clear_tb();
        req_hdr_pend[1] = 1'b1; req_data_pend[1] = 1'b1; req_has[1] = 1'b1;
        req_hdr[1] = 64'h1_0000_0040; req_data[1] = 64'h5a;
        dn_resp_hdr = 64'h2_0000_0040; dn_resp_has = 1'b0;
        apply();
        wait_done(1, 50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_done: got %0b expected 1", ok); end
        checks++; if (ds_hdr_val !== 64'h1_0000_0040) begin
            errors++; $display("FAIL wr_ds_hdr: got %0h expected 100000040", ds_hdr_val); end
        checks++; if (ds_data_val !== 64'h5a || ds_data_cnt !== 1) begin
            errors++; $display("FAIL wr_ds_data: got %0h x%0d expected 5a x1", ds_data_val, ds_data_cnt); end
        checks++; if (up_hdr_cnt[1] !== 1 || up_data_cnt[1] !== 0) begin
            errors++; $display("FAIL wr_resp: got hdr x%0d data x%0d expected 1,0", up_hdr_cnt[1], up_data_cnt[1]); end
        checks++; if (resp_v_seen[0] !== 0 || glog(0) !== 1) begin
            errors++; $display("FAIL wr_owner: got req0 %0d cycles grant %0d expected 0,1", resp_v_seen[0], glog(0)); end
    endtask

    task automatic test_back_to_back_stall();
        bit ok;
        clear_tb();
        req_hdr_pend[0] = 1'b1; req_data_pend[0] = 1'b1; req_has[0] = 1'b1;
        req_hdr[0] = 64'h80; req_data[0] = 64'h1234_5678_9abc_def0;
        cmd_data_delay = 3; resp_data_delay = 5;
        dn_resp_hdr = 64'h4080; dn_resp_has = 1'b1; dn_resp_data = 64'hcafe_f00d;
        apply();
        wait_done(1, 80, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL st_done: got %0b expected 1", ok); end
        checks++; if (ds_hdr_cnt !== 1 || ds_data_cnt !== 1) begin
            errors++; $display("FAIL st_ds_beats: got hdr x%0d data x%0d expected 1,1", ds_hdr_cnt, ds_data_cnt); end
        checks++; if (ds_data_val !== 64'h1234_5678_9abc_def0) begin
            errors++; $display("FAIL st_ds_data: got %0h expected 123456789abcdef0", ds_data_val); end
        checks++; if (up_hdr_cnt[0] !== 1 || up_data_cnt[0] !== 1 || up_data_val[0] !== 64'hcafe_f00d) begin
            errors++; $display("FAIL st_resp: got hdr x%0d data x%0d %0h expected 1,1,cafef00d",
                               up_hdr_cnt[0], up_data_cnt[0], up_data_val[0]); end
    endtask

    task automatic test_data_before_grant();
        bit ok;
        clear_tb();
        req_hdr_pend[0] = 1'b1; req_hdr[0] = 64'h100;
        req_data_pend[1] = 1'b1; req_has[1] = 1'b1; req_hdr[1] = 64'h108; req_data[1] = 64'h77;
        dn_resp_has = 1'b1; dn_resp_data = 64'h55; dn_resp_hdr = 64'h2100; resp_data_delay = 6;
        apply();
        wait_done(1, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL db_first: got %0b expected 1", ok); end
        checks++; if (data_rdy_seen[1] !== 0 || req_data_pend[1] !== 1'b1) begin
            errors++; $display("FAIL db_early_ready: got %0d ready cycles expected 0", data_rdy_seen[1]); end
        checks++; if (ds_data_cnt !== 0) begin
            errors++; $display("FAIL db_ds_data_early: got %0d beats expected 0", ds_data_cnt); end
        req_hdr_pend[1] = 1'b1; dn_resp_has = 1'b0; resp_data_delay = 0;
        apply();
        wait_done(2, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL db_second: got %0b expected 1", ok); end
        checks++; if (ds_data_val !== 64'h77 || ds_data_cnt !== 1 || req_data_pend[1] !== 1'b0) begin
            errors++; $display("FAIL db_data: got %0h x%0d expected 77 x1", ds_data_val, ds_data_cnt); end
        checks++; if (glog(1) !== 1) begin
            errors++; $display("FAIL db_grant: got %0d expected 1", glog(1)); end
    endtask

    initial begin
        reset_i = 1'b1;
        clear_tb();
        apply();
        test_reset();
        test_single_read();
        test_reset_mid();
        test_round_robin();
        test_single_write();
        test_back_to_back_stall();
        test_data_before_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
